sto_sym_aligner: RTL and testbench
==================================

// Module: sto_sym_aligner
// PURPOSE
//  Downstream of the STO estimation datapath. Consumes the 12-bit est_STO, drops
//  est_STO leading samples, then per OFDM symbol strips Ng cyclic-prefix samples
//  and forwards Nfft useful samples, marked with start/end strobes, to the FFT.
//  Free-runs symbol after symbol until re-armed or reset.
// PARAMETERS
//  DW   9   sample width per rail (re/im, two's complement)
//  SCW  8   width of the symbol counter
// PORTS
//  clk        in   1    system clock, all flops rising edge
//  rst_n      in   1    asynchronous active-low reset
//  sto_valid  in   1    1-cycle strobe: est_STO/Nfft/Ng valid, (re)arm aligner
//  est_STO    in   12   samples to discard before first CP
//  Nfft       in   12   useful samples per symbol
//  Ng         in   12   CP length in samples
//  in_valid   in   1    input sample strobe
//  in_re      in   DW   input sample, real
//  in_im      in   DW   input sample, imag
//  out_valid  out  1    output sample strobe
//  out_re     out  DW   output sample, real
//  out_im     out  DW   output sample, imag
//  sym_start  out  1    with out_valid on 1st useful sample of a symbol
//  sym_end    out  1    with out_valid on Nfft-th useful sample
//  sym_cnt    out  SCW  completed symbols since last arm, wraps 2^SCW-1 -> 0
//  busy       out  1    high in any state except IDLE
//  err_cfg    out  1    1-cycle pulse: rejected configuration
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0, latched config 0.
//  sto_valid latches est_STO/Nfft/Ng; config is frozen until next sto_valid.
//  Config check at sto_valid: Nfft==0 or est_STO >= Nfft+Ng (13-bit sum)
//   -> err_cfg=1 next cycle, FSM->IDLE, no output.
//  FSM: IDLE -> SKIP (est_STO>0) | CP (est_STO==0, Ng>0) | DATA (both 0).
//   SKIP: drop est_STO in_valid samples, then CP (or DATA if Ng==0).
//   CP: drop Ng samples, then DATA.
//   DATA: forward Nfft samples, then CP (or DATA again if Ng==0).
//  Counter: load (len-1) on entry; decrement per in_valid;
//   leave state on in_valid with count==0.
//  Sample seen in same cycle as sto_valid is NOT counted in any state.
//  Latency: accepted DATA sample -> out_valid/out_re/out_im exactly 1 cycle later.
//  Input gaps (in_valid=0) produce no output and do not advance counters.
//  out_re/out_im hold last value when out_valid=0.
//  sym_start=1 for count==Nfft-1 in DATA.
//  sym_end=1 for count==0 in DATA.
//  Both are set on the same cycle when Nfft==1.
//  sym_cnt increments in the cycle sym_end is issued; cleared on sto_valid.
//  sto_valid while busy: abort current symbol at once (no sym_end, partial
//   symbol not counted), re-arm with new config. Accepted DATA samples already
//   issued are not retracted.
//  Reset mid-symbol: immediate return to reset state, out_valid drops async.
//  No backpressure: downstream must accept every out_valid.
// TESTING
//  1 Reset: rst_n=0 mid-DATA -> all outputs 0 same cycle; after release, IDLE.
//  2 est_STO=5, Ng=4, Nfft=8, in_valid continuous -> samples 0..8 dropped;
//    9..16 out, sym_start on 9, sym_end on 16.
//  3 Same config, 2 symbols -> samples 21..28 out; sym_cnt=1 then 2.
//  4 est_STO=0, Ng=0, Nfft=4 -> every sample passes 1 cycle late.
//    sym_start/sym_end every 4th; sym_cnt=255 wraps to 0.
//  5 Nfft=8, Ng=4, est_STO=12 -> err_cfg pulse, busy=0, no out_valid.
//    Also Nfft=0 -> err_cfg.
//  6 in_valid 50% random gaps + sto_valid re-arm mid-DATA (est_STO=2) ->
//    no sym_end for aborted symbol; sym_cnt=0; next symbol aligns to new config.

Source files
------------

// File: rtl/sto_sym_aligner.sv
// sto_sym_aligner: drops est_STO leading samples after arming, then per OFDM
// symbol strips Ng cyclic-prefix samples and forwards Nfft useful samples,
// tagged with start/end strobes, to the FFT. Runs symbol after symbol until
// re-armed by sto_valid or reset.
module sto_sym_aligner #(
    parameter int DW  = 9,
    parameter int SCW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sto_valid,
    input  logic [11:0]       est_STO,
    input  logic [11:0]       Nfft,
    input  logic [11:0]       Ng,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_re,
    input  logic [DW-1:0]     in_im,
    output logic              out_valid,
    output logic [DW-1:0]     out_re,
    output logic [DW-1:0]     out_im,
    output logic              sym_start,
    output logic              sym_end,
    output logic [SCW-1:0]    sym_cnt,
    output logic              busy,
    output logic              err_cfg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        CP   = 2'd2,
        DATA = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [11:0]  r_cnt;
    logic [11:0]  w_cnt_nxt;
    logic [11:0]  r_nfft;
    logic [11:0]  r_ng;
    logic [12:0]  w_len_sum;
    logic         w_cfg_bad;
    logic         w_fwd;
    logic         w_start;
    logic         w_end;

    assign w_len_sum = {1'b0, Nfft} + {1'b0, Ng};
    assign w_cfg_bad = (Nfft == '0) || ({1'b0, est_STO} >= w_len_sum);
    assign busy      = (r_state != IDLE);

    // Next-state / down-counter logic; sto_valid overrides any sample in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fwd       = 1'b0;
        w_start     = 1'b0;
        w_end       = 1'b0;
        if (sto_valid) begin
            if (w_cfg_bad) begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end else if (est_STO != '0) begin
                w_state_nxt = SKIP;
                w_cnt_nxt   = est_STO - 12'd1;
            end else if (Ng != '0) begin
                w_state_nxt = CP;
                w_cnt_nxt   = Ng - 12'd1;
            end else begin
                w_state_nxt = DATA;
                w_cnt_nxt   = Nfft - 12'd1;
            end
        end else if (in_valid) begin
            case (r_state)
                SKIP: begin
                    if (r_cnt == '0) begin
                        if (r_ng != '0) begin
                            w_state_nxt = CP;
                            w_cnt_nxt   = r_ng - 12'd1;
                        end else begin
                            w_state_nxt = DATA;
                            w_cnt_nxt   = r_nfft - 12'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 12'd1;
                    end
                end
                CP: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = r_nfft - 12'd1;
                    end else begin
                        w_cnt_nxt = r_cnt - 12'd1;
                    end
                end
                DATA: begin
                    w_fwd   = 1'b1;
                    w_start = (r_cnt == r_nfft - 12'd1);
                    w_end   = (r_cnt == '0);
                    if (r_cnt == '0) begin
                        if (r_ng != '0) begin
                            w_state_nxt = CP;
                            w_cnt_nxt   = r_ng - 12'd1;
                        end else begin
                            w_state_nxt = DATA;
                            w_cnt_nxt   = r_nfft - 12'd1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and sample counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Configuration latch, frozen between arms
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nfft <= '0;
            r_ng   <= '0;
        end else if (sto_valid) begin
            r_nfft <= Nfft;
            r_ng   <= Ng;
        end
    end

    // Output stage: one-cycle latency, data held while out_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            sym_start <= 1'b0;
            sym_end   <= 1'b0;
            err_cfg   <= 1'b0;
        end else begin
            out_valid <= w_fwd;
            sym_start <= w_start;
            sym_end   <= w_end;
            err_cfg   <= sto_valid && w_cfg_bad;
            if (w_fwd) begin
                out_re <= in_re;
                out_im <= in_im;
            end
        end
    end

    // Completed-symbol counter, visible together with sym_end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt <= '0;
        end else if (sto_valid) begin
            sym_cnt <= '0;
        end else if (w_fwd && w_end) begin
            sym_cnt <= sym_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sto_sym_aligner.sv
// Scoreboard bench for sto_sym_aligner: a position-based model predicts each
// forwarded sample when it is driven; the monitor pops and compares outputs.
module tb_sto_sym_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sto_valid = 1'b0;
    logic [11:0] est_STO = '0;
    logic [11:0] Nfft = '0;
    logic [11:0] Ng = '0;
    logic        in_valid = 1'b0;
    logic [8:0]  in_re = '0;
    logic [8:0]  in_im = '0;
    logic        out_valid;
    logic [8:0]  out_re;
    logic [8:0]  out_im;
    logic        sym_start;
    logic        sym_end;
    logic [7:0]  sym_cnt;
    logic        busy;
    logic        err_cfg;

    sto_sym_aligner #(.DW(9), .SCW(8)) dut (
        .clk(clk), .rst_n(rst_n), .sto_valid(sto_valid),
        .est_STO(est_STO), .Nfft(Nfft), .Ng(Ng),
        .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .sym_start(sym_start), .sym_end(sym_end), .sym_cnt(sym_cnt),
        .busy(busy), .err_cfg(err_cfg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] re;
        logic [8:0] im;
        logic       st;
        logic       en;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // model state: stream position since the last accepted arm
    bit   m_armed = 1'b0;
    int   m_sto, m_nfft, m_ng, m_pos, m_done;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_step();
        int k, m, idx;
        exp_t e;
        if (m_pos >= m_sto) begin
            k = m_pos - m_sto;
            m = k % (m_ng + m_nfft);
            if (m >= m_ng) begin
                idx  = m - m_ng;
                e.re = in_re;
                e.im = in_im;
                e.st = (idx == 0);
                e.en = (idx == m_nfft - 1);
                if (e.en) m_done++;
                e.cnt = 8'(m_done);
                q.push_back(e);
            end
        end
        m_pos++;
    endtask

    task automatic cycle(input bit iv);
        @(negedge clk);
        sto_valid = 1'b0;
        in_valid  = iv;
        in_re     = 9'($urandom);
        in_im     = 9'($urandom);
        if (iv && m_armed) model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    // arm with a sample present in the same cycle; that sample must be ignored
    task automatic arm(input int sto, input int nfft, input int ng);
        bit bad;
        @(negedge clk);
        sto_valid = 1'b1;
        est_STO   = 12'(sto);
        Nfft      = 12'(nfft);
        Ng        = 12'(ng);
        in_valid  = 1'b1;
        in_re     = 9'($urandom);
        in_im     = 9'($urandom);
        bad       = (nfft == 0) || (sto >= nfft + ng);
        m_armed   = !bad;
        m_sto     = sto;
        m_nfft    = nfft;
        m_ng      = ng;
        m_pos     = 0;
        m_done    = 0;
        @(negedge clk);
        sto_valid = 1'b0;
        in_valid  = 1'b0;
        chk("err_cfg", 32'(err_cfg), 32'(bad));
        chk("busy_arm", 32'(busy), 32'(!bad));
        chk("symcnt_clr", 32'(sym_cnt), 0);
    endtask

    // output monitor: every out_valid must match the head of the scoreboard
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_re", 32'(out_re), 32'(e.re));
                chk("out_im", 32'(out_im), 32'(e.im));
                chk("sym_start", 32'(sym_start), 32'(e.st));
                chk("sym_end", 32'(sym_end), 32'(e.en));
                chk("sym_cnt", 32'(sym_cnt), 32'(e.cnt));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        // power-on reset
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sym_cnt", 32'(sym_cnt), 0);
        chk("rst_err", 32'(err_cfg), 0);
        rst_n = 1'b1;
        idle(2);

        // reset in the middle of DATA
        arm(0, 4, 0);
        for (int i = 0; i < 6; i++) cycle(1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(out_valid), 1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_sym", 32'({sym_start, sym_end, err_cfg}), 0);
        chk("arst_data", 32'({out_re, out_im, sym_cnt}), 0);
        q.delete();
        m_armed = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 0);

        // est_STO=5, Ng=4, Nfft=8, two symbols continuous
        arm(5, 8, 4);
        for (int i = 0; i < 29; i++) cycle(1'b1);
        idle(3);
        chk("t2_drain", 32'(q.size()), 0);
        chk("t3_symcnt", 32'(sym_cnt), 2);

        // pass-through, sym_cnt wraps after 256 symbols
        arm(0, 4, 0);
        for (int i = 0; i < 1024; i++) cycle(1'b1);
        idle(3);
        chk("t4_drain", 32'(q.size()), 0);
        chk("t4_wrap", 32'(sym_cnt), 0);
        chk("t4_busy", 32'(busy), 1);

        // rejected configurations
        arm(12, 8, 4);
        idle(1);
        chk("t5_err_pulse", 32'(err_cfg), 0);
        for (int i = 0; i < 20; i++) cycle(1'b1);
        chk("t5_busy", 32'(busy), 0);
        arm(0, 0, 3);
        for (int i = 0; i < 10; i++) cycle(1'b1);
        idle(2);
        arm(11, 8, 4);
        for (int i = 0; i < 30; i++) cycle(1'b1);
        idle(3);
        chk("t5_edge_drain", 32'(q.size()), 0);

        // random gaps with a re-arm in the middle of DATA
        arm(3, 8, 4);
        for (int i = 0; i < 200 && m_pos < 10; i++) cycle(1'($urandom_range(0, 1)));
        chk("t6_reached_data", 32'(m_pos >= 10), 1);
        arm(2, 8, 4);
        for (int i = 0; i < 80; i++) cycle(1'($urandom_range(0, 1)));
        idle(3);
        chk("t6_drain", 32'(q.size()), 0);
        chk("t6_symcnt", 32'(sym_cnt), 32'(8'(m_done)));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
